// File: rtl/g9_pkg.sv
// -----------------------------------------------------------------------------
// g9_pkg
// Constants shared by the G9 processor, its instruction memory and the boot
// loader: instruction width, instruction-memory depth and the loader FSM
// state encoding.
// -----------------------------------------------------------------------------
package g9_pkg;

    localparam int INSTR_W  = 32;   // instruction word / address width
    localparam int MEM_SIZE = 512;  // instruction-memory depth in words

    // Loader states. The four receiving states are numerically contiguous
    // (0..3), which keeps the byte_ready decode small.
    localparam logic [2:0] ST_LEN_HI = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CSUM   = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs four consecutive strobed bytes, MSB first, into one word. After the
// fourth byte the completed word is latched and word_valid pulses for one
// cycle.
//   clk, reset     : clock, synchronous active-high reset
//   i_byte         : stream byte
//   i_strobe       : i_byte is consumed this cycle
//   o_word         : last completed word (held between completions)
//   o_word_valid   : one-cycle pulse, o_word is new this cycle
// -----------------------------------------------------------------------------
module word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_byte,
    input  logic              i_strobe,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [1:0]        r_cnt;
    logic [WORD_W-9:0] r_shift;
    logic [WORD_W-1:0] r_word;
    logic              r_word_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 2'd0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_strobe) begin
                r_cnt   <= r_cnt + 2'd1;  // wraps modulo 4
                r_shift <= {r_shift[WORD_W-17:0], i_byte};
                // Fourth byte: the earlier three sit in r_shift, this one
                // completes the word directly so no extra cycle is spent.
                if (r_cnt == 2'd3) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Receives a length-prefixed, XOR-checksummed byte stream and writes it into
// the G9 instruction memory, holding the processor in reset until the image
// is complete and verified.
//   clk, reset           : clock, synchronous active-high reset
//   byte_valid/byte_data : input byte stream
//   byte_ready           : a byte is accepted this cycle when valid & ready
//   imem_wea/addra/dina  : instruction-memory write port (one-cycle pulses)
//   cpu_reset            : 1 until the image has loaded and verified
//   done                 : image loaded, checksum matched
//   error                : oversize length or checksum mismatch
// -----------------------------------------------------------------------------
module boot_loader
    import g9_pkg::*;
#(
    parameter int size    = INSTR_W,
    parameter int MemSize = MEM_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            imem_wea,
    output logic [size-1:0] imem_addra,
    output logic [size-1:0] imem_dina,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);

    localparam logic [15:0] MEM_WORDS = 16'(MemSize);

    logic [2:0]      r_state;
    logic [7:0]      r_csum;
    logic [7:0]      r_len_hi;
    logic [17:0]     r_bytes_left;
    logic [15:0]     r_word_idx;
    logic            r_cpu_reset;
    logic            r_done;
    logic            r_error;

    logic            w_accept;
    logic [15:0]     w_len;
    logic [size-1:0] w_word;
    logic            w_word_valid;

    assign byte_ready = ~reset & ((r_state == ST_LEN_HI) | (r_state == ST_LEN_LO) |
                                  (r_state == ST_DATA)   | (r_state == ST_CSUM));
    assign w_accept   = byte_valid & byte_ready;
    assign w_len      = {r_len_hi, byte_data};

    word_assembler #(.WORD_W(size)) u_word_asm (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (byte_data),
        .i_strobe     (w_accept & (r_state == ST_DATA)),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_LEN_HI;
            r_csum       <= 8'd0;
            r_len_hi     <= 8'd0;
            r_bytes_left <= 18'd0;
            r_word_idx   <= 16'd0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Address advances after the write cycle that used it.
            if (w_word_valid) begin
                r_word_idx <= r_word_idx + 16'd1;
            end
            if (w_accept) begin
                r_csum <= r_csum ^ byte_data;
                case (r_state)
                    ST_LEN_HI: begin
                        r_len_hi <= byte_data;
                        r_state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        if (w_len > MEM_WORDS) begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state      <= ST_DATA;
                            r_bytes_left <= {w_len, 2'b00};
                        end
                    end
                    ST_DATA: begin
                        r_bytes_left <= r_bytes_left - 18'd1;
                        if (r_bytes_left == 18'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (byte_data == r_csum) begin
                            r_state     <= ST_RUN;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_wea   = w_word_valid;
    assign imem_addra = {{(size-16){1'b0}}, r_word_idx};
    assign imem_dina  = w_word;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Directed bench for boot_loader: normal, bad-checksum, empty, oversize,
// throttled and reset-mid-load streams, with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_wea;
    logic [31:0] imem_addra;
    logic [31:0] imem_dina;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    // Write monitor, sampled on the falling edge.
    int   wr_total = 0;
    int   wr_b2b   = 0;
    logic prev_wea = 1'b0;

    logic [7:0] nrm [0:10];

    always #5 clk = ~clk;

    boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always @(negedge clk) begin
        if (imem_wea === 1'b1) begin
            wr_total++;
            if (prev_wea) wr_b2b++;
        end
        prev_wea = (imem_wea === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("ready_in_reset", {31'd0, byte_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_wea",   {31'd0, imem_wea},  32'd0);
        chk("rst_addr",  imem_addra,         32'd0);
        chk("rst_dina",  imem_dina,          32'd0);
        chk("rst_cpurst",{31'd0, cpu_reset}, 32'd1);
        chk("rst_done",  {31'd0, done},      32'd0);
        chk("rst_error", {31'd0, error},     32'd0);
        chk("rst_ready", {31'd0, byte_ready},32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
    endtask

    // Sends the first n bytes of the normal stream (last byte replaced when
    // n==11), checking the write port after each accepted byte.
    task automatic load(input int n, input logic [7:0] lastb, input bit thr);
        for (int i = 0; i < n; i++) begin
            if (thr) begin
                int g;
                g = $urandom_range(1, 5);
                repeat (g) begin
                    byte_data = 8'hFF;
                    @(posedge clk); #1;
                    chk("gap_wea", {31'd0, imem_wea}, 32'd0);
                end
            end
            send((i == 10) ? lastb : nrm[i]);
            if (i == 5) begin
                chk("w0_wea",  {31'd0, imem_wea}, 32'd1);
                chk("w0_addr", imem_addra, 32'd0);
                chk("w0_data", imem_dina,  32'h8C220004);
            end else if (i == 9) begin
                chk("w1_wea",  {31'd0, imem_wea}, 32'd1);
                chk("w1_addr", imem_addra, 32'd1);
                chk("w1_data", imem_dina,  32'h00000001);
            end else begin
                chk("no_wea",  {31'd0, imem_wea}, 32'd0);
            end
        end
    endtask

    task automatic chk_final_run();
        chk("run_done",  {31'd0, done},       32'd1);
        chk("run_cpurst",{31'd0, cpu_reset},  32'd0);
        chk("run_error", {31'd0, error},      32'd0);
        chk("run_ready", {31'd0, byte_ready}, 32'd0);
    endtask

    initial begin
        int w0;
        nrm = '{8'h00, 8'h02, 8'h8C, 8'h22, 8'h00, 8'h04,
                8'h00, 8'h00, 8'h00, 8'h01, 8'hA9};
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Normal load
        w0 = wr_total;
        load(11, 8'hA9, 1'b0);
        chk_final_run();
        @(posedge clk); #1;
        chk("norm_wr_cnt", 32'(wr_total - w0), 32'd2);

        // Bad checksum
        do_reset();
        w0 = wr_total;
        load(11, 8'h00, 1'b0);
        chk("bad_error", {31'd0, error},      32'd1);
        chk("bad_cpurst",{31'd0, cpu_reset},  32'd1);
        chk("bad_done",  {31'd0, done},       32'd0);
        chk("bad_ready", {31'd0, byte_ready}, 32'd0);
        for (int i = 0; i < 8; i++) send(8'h5A);
        chk("bad_wr_cnt", 32'(wr_total - w0), 32'd2);
        chk("bad_error2", {31'd0, error},     32'd1);
        chk("bad_done2",  {31'd0, done},      32'd0);

        // Empty image
        do_reset();
        w0 = wr_total;
        send(8'h00);
        send(8'h00);
        chk("empty_done_early", {31'd0, done}, 32'd0);
        send(8'h00);
        chk("empty_done",   {31'd0, done},      32'd1);
        chk("empty_cpurst", {31'd0, cpu_reset}, 32'd0);
        chk("empty_error",  {31'd0, error},     32'd0);
        @(posedge clk); #1;
        chk("empty_wr_cnt", 32'(wr_total - w0), 32'd0);

        // Oversize image (N = 513)
        do_reset();
        w0 = wr_total;
        send(8'h02);
        chk("over_err_early", {31'd0, error}, 32'd0);
        send(8'h01);
        chk("over_error",  {31'd0, error},      32'd1);
        chk("over_ready",  {31'd0, byte_ready}, 32'd0);
        chk("over_cpurst", {31'd0, cpu_reset},  32'd1);
        chk("over_done",   {31'd0, done},       32'd0);
        for (int i = 0; i < 6; i++) send(8'h11);
        chk("over_wr_cnt", 32'(wr_total - w0), 32'd0);

        // Boundary length N = 512 is accepted
        do_reset();
        send(8'h02);
        send(8'h00);
        chk("max_len_error", {31'd0, error},      32'd0);
        chk("max_len_ready", {31'd0, byte_ready}, 32'd1);

        // Throttled input
        do_reset();
        w0 = wr_total;
        load(11, 8'hA9, 1'b1);
        chk_final_run();
        @(posedge clk); #1;
        chk("thr_wr_cnt", 32'(wr_total - w0), 32'd2);

        // Reset mid-load, then full reload
        do_reset();
        load(6, 8'h00, 1'b0);
        @(posedge clk); #1;
        do_reset();
        w0 = wr_total;
        load(11, 8'hA9, 1'b0);
        chk_final_run();
        @(posedge clk); #1;
        chk("reload_wr_cnt", 32'(wr_total - w0), 32'd2);

        chk("no_b2b_wea", 32'(wr_b2b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
